// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants and helpers.
// Used by the encoder, the corrector and the receive deserialiser.
package hamming_pkg;

    localparam int CW_WIDTH    = 15;
    localparam int DATA_WIDTH  = 11;
    localparam int PARITY_BITS = 4;

    // Parity bit positions (1-based Hamming positions)
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Where the cnt-th received bit lands inside a codeword register
    function automatic int cw_bit_index(
        input int cnt,
        input int width,
        input bit lsb_first
    );
        return lsb_first ? cnt : (width - 1 - cnt);
    endfunction

    // True when a 1-based Hamming position carries a parity bit
    function automatic bit is_parity_pos(input int pos);
        return (pos == P1_POS) || (pos == P2_POS) ||
               (pos == P4_POS) || (pos == P8_POS);
    endfunction

endpackage

// File: rtl/cw_hold_reg.sv
// Single-entry valid/ready holding register.
// load_ok tells the producer a load this cycle will be taken.
module cw_hold_reg #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             load_ok
);

    // Slot is free now, or is being emptied this same cycle
    always_comb begin
        load_ok = !valid || ready;
    end

    // Load a new word, or drop valid once the held word is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load && load_ok) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hamming_rx_deser.sv
// Serial-to-parallel front end of the Hamming(15,11) receiver.
// Assembles codewords, realigns on frame_start, counts dropped words.
module hamming_rx_deser
    import hamming_pkg::*;
#(
    parameter int CW_WIDTH  = hamming_pkg::CW_WIDTH,
    parameter int LSB_FIRST = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_start,
    output logic [CW_WIDTH-1:0]  cw_data,
    output logic                 cw_valid,
    input  logic                 cw_ready,
    output logic                 overrun,
    output logic                 realign,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int IDX_W = $clog2(CW_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_WIDTH - 1);

    logic [IDX_W-1:0]    bit_cnt;
    logic [IDX_W-1:0]    cnt_eff;
    logic [IDX_W-1:0]    wr_pos;
    logic [CW_WIDTH-1:0] asm_q;
    logic [CW_WIDTH-1:0] asm_next;
    logic                word_done;
    logic                load_ok;
    logic                realign_d;
    logic                overrun_d;
    logic                drop_ev;

    // A frame_start bit always restarts the word at slot 0
    always_comb begin
        cnt_eff = frame_start ? '0 : bit_cnt;
        wr_pos  = IDX_W'(cw_bit_index(int'(cnt_eff), CW_WIDTH,
                                      LSB_FIRST != 0));
    end

    // Word as it looks including this cycle's bit
    always_comb begin
        asm_next = (cnt_eff == '0) ? '0 : asm_q;
        asm_next[wr_pos] = bit_in;
    end

    // Completion, realignment and drop detection
    always_comb begin
        word_done = bit_valid && (cnt_eff == LAST_IDX);
        realign_d = bit_valid && frame_start && (bit_cnt != '0);
        overrun_d = word_done && !load_ok;
        drop_ev   = realign_d || overrun_d;
    end

    // Bit counter and assembly register advance only on valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            asm_q   <= '0;
        end else if (bit_valid) begin
            bit_cnt <= word_done ? '0 : cnt_eff + 1'b1;
            asm_q   <= asm_next;
        end
    end

    // Registered event pulses and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            realign    <= 1'b0;
            drop_count <= '0;
        end else begin
            overrun <= overrun_d;
            realign <= realign_d;
            if (drop_ev && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    cw_hold_reg #(
        .WIDTH(CW_WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (word_done),
        .din     (asm_next),
        .ready   (cw_ready),
        .dout    (cw_data),
        .valid   (cw_valid),
        .load_ok (load_ok)
    );

endmodule
